// File: rtl/asm_enc.sv
// Symbolic-instruction encoder streaming packed 16-bit words to instruction memory.
// Latency: word valid the cycle after accept; LI16 emits LIL then LIH. Stalls hold word and address while out_ready is low.
module asm_enc #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        kind,
    input  logic [1:0]        rw,
    input  logic [1:0]        ra,
    input  logic [1:0]        rb,
    input  logic [3:0]        alu,
    input  logic [2:0]        cond,
    input  logic [15:0]       imm,
    input  logic              addr_ld,
    input  logic [ADDR_W-1:0] addr_base,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] iw_addr,
    output logic [15:0]       iw_data,
    output logic              err,
    output logic              full
);

    typedef enum logic [1:0] {IDLE, EMIT, EMIT_HI} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       data_q, data_d;
    logic [15:0]       hi_q, hi_d;
    logic              two_q, two_d;
    logic              err_q, err_d;
    logic              full_q, full_d;

    logic [15:0] enc_lo, enc_hi;
    logic        enc_two, enc_rej, needs_imm, imm_ok;
    logic [7:0]  im;
    logic        accept, out_fire;

    always_comb begin
        im        = imm[7:0];
        imm_ok    = (imm[15:8] == 8'h00) || (&imm[15:7]);
        needs_imm = 1'b0;
        enc_lo    = 16'h0000;
        enc_hi    = 16'h0000;
        enc_two   = 1'b0;
        case (kind)
            4'd0:  enc_lo = 16'h0000;
            4'd1:  enc_lo = 16'h0001;
            4'd2:  enc_lo = {8'b0000_0001, alu, ra, rb};
            4'd3:  begin enc_lo = {6'b0000_01, rw, im}; needs_imm = 1'b1; end
            4'd4:  begin enc_lo = {6'b0000_10, rb, im}; needs_imm = 1'b1; end
            4'd5:  enc_lo = {5'b0001_0, cond, alu, ra, rb};
            4'd6:  begin enc_lo = {5'b0001_1, cond, im}; needs_imm = 1'b1; end
            4'd7:  begin enc_lo = {5'b0010_0, cond, im}; needs_imm = 1'b1; end
            4'd8:  enc_lo = {5'b0010_1, 1'b0, rw, alu, ra, rb};
            4'd9:  begin
                // LI16 splits into low then high half, each writing rw.
                enc_lo  = {4'b0100, rw, rw, imm[7:0]};
                enc_hi  = {4'b0101, rw, rw, imm[15:8]};
                enc_two = 1'b1;
            end
            4'd10: begin enc_lo = {6'b1000_00, rw, im}; needs_imm = 1'b1; end
            4'd11: begin enc_lo = {4'b1001, ra, rb, im}; needs_imm = 1'b1; end
            4'd12: enc_lo = {4'b1010, rw, 2'b00, alu, ra, rb};
            4'd13: begin enc_lo = {4'b1011, rw, ra, im}; needs_imm = 1'b1; end
            4'd14: begin enc_lo = {3'b110, alu[0], rw, ra, im}; needs_imm = 1'b1; end
            default: begin enc_lo = {3'b111, ra, cond, im}; needs_imm = 1'b1; end
        endcase
        enc_rej = (needs_imm && !imm_ok) || ((kind == 4'd14) && (alu[3:1] != 3'b000));
    end

    always_comb begin
        in_ready  = (state_q == IDLE) && !addr_ld;
        out_valid = (state_q != IDLE);
        iw_addr   = addr_q;
        iw_data   = data_q;
        err       = err_q;
        full      = full_q;
    end

    assign accept   = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        hi_d    = hi_q;
        two_d   = two_q;
        full_d  = full_q;
        err_d   = accept && enc_rej;
        case (state_q)
            IDLE: begin
                if (addr_ld) begin
                    addr_d = addr_base;
                    full_d = 1'b0;
                end else if (accept && !enc_rej) begin
                    data_d  = enc_lo;
                    hi_d    = enc_hi;
                    two_d   = enc_two;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (out_fire) begin
                    state_d = two_q ? EMIT_HI : IDLE;
                    if (two_q) data_d = hi_q;
                end
            end
            default: begin
                if (out_fire) state_d = IDLE;
            end
        endcase
        if (out_fire) begin
            addr_d = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            if (&addr_q) full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= 16'h0000;
            hi_q    <= 16'h0000;
            two_q   <= 1'b0;
            err_q   <= 1'b0;
            full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            hi_q    <= hi_d;
            two_q   <= two_d;
            err_q   <= err_d;
            full_q  <= full_d;
        end
    end

endmodule

// File: tb/tb_asm_enc.sv
// Bench for asm_enc: directed and random instructions, scoreboard of expected words and rejects.
module tb_asm_enc;

    logic        clk, rst_n;
    logic        in_valid, in_ready;
    logic [3:0]  kind;
    logic [1:0]  rw, ra, rb;
    logic [3:0]  alu;
    logic [2:0]  cond;
    logic [15:0] imm;
    logic        addr_ld;
    logic [7:0]  addr_base;
    logic        out_valid, out_ready;
    logic [7:0]  iw_addr;
    logic [15:0] iw_data;
    logic        err, full;

    asm_enc #(.ADDR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .kind(kind), .rw(rw), .ra(ra), .rb(rb), .alu(alu), .cond(cond), .imm(imm),
        .addr_ld(addr_ld), .addr_base(addr_base), .out_valid(out_valid),
        .out_ready(out_ready), .iw_addr(iw_addr), .iw_data(iw_data),
        .err(err), .full(full)
    );

    typedef struct {
        bit          is_err;
        logic [7:0]  addr;
        logic [15:0] data;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    logic [7:0]  nxt_addr = 8'h00;
    bit          model_full = 0;
    bit          rand_rdy = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: event missing or unexpected at %0t", name, $time);
    endtask

    // Reference encoder written with field weights rather than bit packing.
    function automatic void model(input int k, input int w, input int a, input int b,
                                  input int op, input int c, input int iv,
                                  output bit rej, output bit two,
                                  output logic [15:0] lo, output logic [15:0] hi);
        int im, r;
        bit ok;
        im  = iv % 256;
        ok  = (iv < 256) || (iv >= 'hFF80);
        two = 0;
        hi  = 16'h0;
        rej = 0;
        case (k)
            0:  r = 0;
            1:  r = 1;
            2:  r = 'h0100 + op*16 + a*4 + b;
            3:  begin r = 'h0400 + w*256 + im; rej = !ok; end
            4:  begin r = 'h0800 + b*256 + im; rej = !ok; end
            5:  r = 'h1000 + c*256 + op*16 + a*4 + b;
            6:  begin r = 'h1800 + c*256 + im; rej = !ok; end
            7:  begin r = 'h2000 + c*256 + im; rej = !ok; end
            8:  r = 'h2800 + w*256 + op*16 + a*4 + b;
            9:  begin
                r = 'h4000 + w*1024 + w*256 + im;
                hi = 16'('h5000 + w*1280 + iv/256);
                two = 1;
            end
            10: begin r = 'h8000 + w*256 + im; rej = !ok; end
            11: begin r = 'h9000 + a*1024 + b*256 + im; rej = !ok; end
            12: r = 'hA000 + w*1024 + op*16 + a*4 + b;
            13: begin r = 'hB000 + w*1024 + a*256 + im; rej = !ok; end
            14: begin r = 'hC000 + (op%2)*4096 + w*1024 + a*256 + im; rej = !ok || (op > 1); end
            default: begin r = 'hE000 + a*2048 + c*256 + im; rej = !ok; end
        endcase
        lo = 16'(r);
    endfunction

    task automatic send(input int k, input int w, input int a, input int b,
                        input int op, input int c, input int iv);
        bit rej, two;
        logic [15:0] lo, hi;
        int n;
        exp_t e;
        @(negedge clk);
        kind = 4'(k); rw = 2'(w); ra = 2'(a); rb = 2'(b);
        alu = 4'(op); cond = 3'(c); imm = 16'(iv);
        in_valid = 1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            fail_now("send_timeout");
            in_valid = 0;
            return;
        end
        model(k, w, a, b, op, c, iv, rej, two, lo, hi);
        if (rej) begin
            e.is_err = 1; e.addr = 8'h0; e.data = 16'h0;
            sb.push_back(e);
        end else begin
            e.is_err = 0; e.addr = nxt_addr; e.data = lo;
            sb.push_back(e);
            nxt_addr++;
            if (two) begin
                e.addr = nxt_addr; e.data = hi;
                sb.push_back(e);
                nxt_addr++;
            end
        end
        @(negedge clk);
        in_valid = 0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((out_valid || sb.size() != 0) && n < 2000);
        if (out_valid || sb.size() != 0) fail_now("drain_timeout");
    endtask

    task automatic load_addr(input logic [7:0] b);
        wait_idle();
        addr_ld = 1;
        addr_base = b;
        nxt_addr = b;
        @(negedge clk);
        addr_ld = 0;
        model_full = 0;
        #1;
        chk("addr_ld_iw_addr", iw_addr, b);
        chk("addr_ld_full_clr", full, 0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pops the scoreboard on every word handshake and every err pulse.
    initial begin
        bit prev_stall, chk_full;
        logic [7:0] pa;
        logic [15:0] pd;
        exp_t e;
        prev_stall = 0;
        chk_full = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 0;
                chk_full = 0;
            end else begin
                if (chk_full) begin
                    chk("full_flag", full, model_full);
                    chk_full = 0;
                end
                if (prev_stall)
                    chk("stall_hold", {out_valid, in_ready, iw_addr, iw_data}, {1'b1, 1'b0, pa, pd});
                if (err) begin
                    if (sb.size() == 0) fail_now("err_unexpected");
                    else begin
                        e = sb.pop_front();
                        chk("err_expected", 1, e.is_err);
                    end
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) fail_now("word_unexpected");
                    else begin
                        e = sb.pop_front();
                        chk("word", {7'h0, 1'b0, iw_addr, iw_data}, {7'h0, e.is_err, e.addr, e.data});
                        if (e.addr == 8'hFF) model_full = 1;
                        chk_full = 1;
                    end
                end
                prev_stall = out_valid && !out_ready;
                pa = iw_addr;
                pd = iw_data;
            end
        end
    end

    initial begin
        rst_n = 0; in_valid = 0; kind = 0; rw = 0; ra = 0; rb = 0; alu = 0; cond = 0;
        imm = 0; addr_ld = 0; addr_base = 0; out_ready = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_iw_addr", iw_addr, 0);
        chk("rst_iw_data", iw_data, 0);
        chk("rst_err_full", {err, full}, 0);
        @(negedge clk);
        #2 rst_n = 1;

        // LI16, then reset while the high word waits.
        send(9, 1, 0, 0, 0, 0, 'h1234);
        @(posedge clk); #1 out_ready = 1;
        @(posedge clk); #1 out_ready = 0;
        @(negedge clk); #1;
        chk("li16_hi_pending", {out_valid, in_ready, iw_addr, iw_data}, {1'b1, 1'b0, 8'h01, 16'h5512});
        #1 rst_n = 0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_addr_data", {iw_addr, iw_data}, 0);
        chk("midrst_err_full", {err, full}, 0);
        sb.delete();
        nxt_addr = 0;
        model_full = 0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1;
        @(posedge clk); #1 out_ready = 1;

        load_addr(8'h10);
        send(3, 2, 0, 0, 0, 0, 'h0005);
        wait_idle();
        chk("addr_after_li", iw_addr, 8'h11);

        send(14, 3, 1, 0, 1, 0, 'hFFFF);
        send(14, 3, 1, 0, 2, 0, 'h0005);
        send(3, 1, 0, 0, 0, 0, 'h0180);
        wait_idle();
        chk("addr_after_rejects", iw_addr, 8'h12);

        send(15, 0, 2, 0, 0, 5, 'h0010);
        send(8, 1, 2, 3, 'hB, 0, 0);
        wait_idle();

        @(posedge clk); #1 out_ready = 0;
        send(1, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        #1;
        chk("stall_addr", {out_valid, iw_addr, iw_data}, {1'b1, 8'h14, 16'h0001});
        @(posedge clk); #1 out_ready = 1;
        wait_idle();
        chk("addr_after_stall", iw_addr, 8'h15);

        load_addr(8'hFF);
        send(0, 0, 0, 0, 0, 0, 0);
        wait_idle();
        chk("wrap_addr", iw_addr, 8'h00);
        chk("wrap_full", full, 1);
        load_addr(8'h20);

        rand_rdy = 1;
        for (int i = 0; i < 300; i++) begin
            int sel, iv;
            if ($urandom_range(0, 19) == 0) load_addr(8'($urandom));
            sel = $urandom_range(0, 2);
            if (sel == 0) iv = $urandom_range(0, 255);
            else if (sel == 1) iv = 'hFF80 + $urandom_range(0, 127);
            else iv = $urandom_range(0, 'hFFFF);
            send($urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 7), iv);
        end
        wait_idle();
        chk("scoreboard_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
